spi_flash_responder: RTL

SPI flash responder: the target side of the serial read protocol issued by the SPI flash read controller. It decodes the read command and 24-bit address on MOSI, fetches bytes from a local synchronous memory port, and shifts them out on MISO with address auto-increment. Uses: flash model in system testbenches, and an FPGA-side ROM/boot image served over the same four-wire bus.

---
 rtl/spi_flash_responder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI flash read responder (mode 3). Decodes 0x03 reads and streams bytes from a sync memory port.
// Define SPI_FLASH_RESP_FAST_READ_EN to also accept 0x0B fast read with an 8-bit dummy phase.
module spi_flash_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        rd_en,
    output logic [23:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        cmd_err
);
    localparam logic [7:0] OP_READ      = 8'h03;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        , S_DUMMY
`endif
    } state_t;

    logic [1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic        sclk_prev_q;
    logic        sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

    state_t      state_q;
    logic [4:0]  bit_cnt_q;
    logic [6:0]  cmd_q;
    logic [22:0] addr_q;
    logic [7:0]  shift_q, pf_q;
    logic        first_q, use_pf_q, rd_vld_q;
    logic        miso_q, miso_oe_q, rd_en_q, cmd_err_q;
    logic [23:0] rd_addr_q;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    logic        fast_q;
`endif

    logic [7:0]  opcode;
    logic [23:0] addr_full;
    logic        reload;
    logic [7:0]  shift_src;
    logic        in_stream;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 2'b11;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign opcode    = {cmd_q, mosi_s};
    assign addr_full = {addr_q, mosi_s};
    // Every byte after the first comes from the prefetch register at its first falling edge.
    assign reload    = (bit_cnt_q[2:0] == 3'd0) && use_pf_q;
    assign shift_src = reload ? pf_q : shift_q;

    always_comb begin
        in_stream = (state_q == S_DATA);
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        if (state_q == S_DUMMY) in_stream = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            pf_q      <= '0;
            first_q   <= 1'b0;
            use_pf_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            cmd_err_q <= 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            fast_q    <= 1'b0;
`endif
        end else begin
            rd_en_q   <= 1'b0;
            cmd_err_q <= 1'b0;
            rd_vld_q  <= rd_en_q;
            if (cs_s) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
                rd_vld_q  <= 1'b0;
                first_q   <= 1'b0;
                use_pf_q  <= 1'b0;
            end else begin
                // First returned byte goes straight to the shifter and triggers the prefetch.
                if (rd_vld_q && in_stream) begin
                    if (first_q) begin
                        shift_q   <= rd_data;
                        first_q   <= 1'b0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= rd_addr_q + 24'd1;
                    end else begin
                        pf_q <= rd_data;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        state_q   <= S_CMD;
                        bit_cnt_q <= '0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                        fast_q    <= 1'b0;
`endif
                    end
                    S_CMD: if (sclk_rise) begin
                        cmd_q <= {cmd_q[5:0], mosi_s};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            if (opcode == OP_READ) begin
                                state_q <= S_ADDR;
                            end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                            else if (opcode == OP_FAST_READ) begin
                                state_q <= S_ADDR;
                                fast_q  <= 1'b1;
                            end
`endif
                            else begin
                                cmd_err_q <= 1'b1;
                                state_q   <= S_IGNORE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    S_ADDR: if (sclk_rise) begin
                        addr_q <= {addr_q[21:0], mosi_s};
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_full;
                            first_q   <= 1'b1;
                            use_pf_q  <= 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                            if (fast_q) state_q <= S_DUMMY;
                            else
`endif
                            begin
                                state_q   <= S_DATA;
                                miso_oe_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                    S_DUMMY: if (sclk_rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_DATA;
                            miso_oe_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
`endif
                    S_DATA: if (sclk_fall) begin
                        miso_q    <= shift_src[7];
                        shift_q   <= {shift_src[6:0], 1'b0};
                        use_pf_q  <= 1'b1;
                        bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
                        if (reload) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_addr_q + 24'd1;
                        end
                    end
                    S_IGNORE: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign miso    = miso_q;
    assign miso_oe = miso_oe_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = ~cs_s;
    assign cmd_err = cmd_err_q;
endmodule
